// File: rtl/register_file_pkg.sv
// Shared CPU parameters used by the register file and the reorder buffer.
package register_file_pkg;

    localparam int         ROB_WIDTH_DEFAULT = 4;
    localparam int         REG_COUNT         = 32;
    localparam int         REG_ADDR_WIDTH    = 5;
    localparam int         XLEN              = 32;
    localparam logic [4:0] X0_INDEX          = 5'd0;

    // True when a register index names the hardwired zero register.
    function automatic logic is_x0(input logic [REG_ADDR_WIDTH-1:0] idx);
        return idx == X0_INDEX;
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file with rename tracking for a ROB-based core.
// Each register carries a busy bit and the ROB tag of its pending producer;
// a tag-to-rd table lets the ROB commit by tag alone.
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      clear_signal,
    input  logic                      issue_signal,
    input  logic                      issue_rd_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [ROB_WIDTH-1:0]      issue_tag,
    input  logic                      reg_done,
    input  logic [XLEN-1:0]           reg_value,
    input  logic [ROB_WIDTH-1:0]      reg_tag,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [XLEN-1:0]           rs1_value,
    output logic [XLEN-1:0]           rs2_value,
    output logic [ROB_WIDTH-1:0]      rs1_tag,
    output logic [ROB_WIDTH-1:0]      rs2_tag
);

    localparam int ROB_SIZE = 2 ** ROB_WIDTH;

    logic [XLEN-1:0]           regs     [REG_COUNT];
    logic [REG_COUNT-1:0]      busy;
    logic [ROB_WIDTH-1:0]      tags     [REG_COUNT];
    logic [REG_ADDR_WIDTH-1:0] rd_table [ROB_SIZE];

    logic                      issue_fire;
    logic                      issue_writes_rd;
    logic                      commit_fire;
    logic                      clear_fire;
    logic [REG_ADDR_WIDTH-1:0] commit_rd;
    logic                      commit_writes_rd;
    logic                      commit_tag_match;

    // A flush cancels any issue in the same cycle; commits still retire.
    assign issue_fire       = issue_signal & rdy_in & ~clear_signal;
    assign issue_writes_rd  = issue_fire & issue_rd_valid & ~is_x0(issue_rd);
    assign commit_fire      = reg_done & rdy_in;
    assign clear_fire       = clear_signal & rdy_in;
    assign commit_rd        = rd_table[reg_tag];
    assign commit_writes_rd = commit_fire & ~is_x0(commit_rd);
    assign commit_tag_match = (tags[commit_rd] == reg_tag);

    // Tag-to-rd table: remember which rd each allocated ROB line will write.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_table[i] <= X0_INDEX;
            end
        end else if (issue_fire) begin
            rd_table[issue_tag] <= issue_rd_valid ? issue_rd : X0_INDEX;
        end
    end

    // Register values: committed results land here; x0 is never written.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_writes_rd) begin
            regs[commit_rd] <= reg_value;
        end
    end

    // Busy/tag tracking: issue after commit so a same-cycle reissue stays busy.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                tags[i] <= '0;
            end
        end else if (clear_fire) begin
            busy <= '0;
        end else begin
            if (commit_writes_rd && commit_tag_match) begin
                busy[commit_rd] <= 1'b0;
            end
            if (issue_writes_rd) begin
                busy[issue_rd] <= 1'b1;
                tags[issue_rd] <= issue_tag;
            end
        end
    end

    // rs1 lookup with same-cycle commit bypass; x0 always reads as idle zero.
    always_comb begin
        rs1_busy  = 1'b0;
        rs1_value = '0;
        rs1_tag   = '0;
        if (!is_x0(rs1)) begin
            rs1_tag = tags[rs1];
            if (busy[rs1] && reg_done && (tags[rs1] == reg_tag)) begin
                rs1_value = reg_value;
            end else begin
                rs1_busy  = busy[rs1];
                rs1_value = regs[rs1];
            end
        end
    end

    // rs2 lookup, identical rules to rs1.
    always_comb begin
        rs2_busy  = 1'b0;
        rs2_value = '0;
        rs2_tag   = '0;
        if (!is_x0(rs2)) begin
            rs2_tag = tags[rs2];
            if (busy[rs2] && reg_done && (tags[rs2] == reg_tag)) begin
                rs2_value = reg_value;
            end else begin
                rs2_busy  = busy[rs2];
                rs2_value = regs[rs2];
            end
        end
    end

endmodule
